// File: rtl/bcd_tick_counter.sv
// Multi-digit packed BCD up/down counter advanced by a one-clock tick pulse.
// Supports run/pause, sanitising parallel load, and a one-clock wrap pulse.
module bcd_tick_counter #(
   parameter int NUM_DIGITS   = 2,
   parameter int RUN_ON_RESET = 1
) (
   input  logic                    sys_clk,
   input  logic                    sys_reset,
   input  logic                    tick,
   input  logic                    down,
   input  logic                    run_toggle,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    running,
   output logic                    wrap
);

   localparam logic RUN_RESET = (RUN_ON_RESET != 0);

   logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
   logic                    running_q, running_d;
   logic                    wrap_q, wrap_d;

   logic [4*NUM_DIGITS-1:0] ld_clean;
   logic [4*NUM_DIGITS-1:0] step_val;
   logic [3:0]              dig;
   logic                    chain;
   logic                    step;

   always_comb begin
      ld_clean = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         ld_clean[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd0 : load_value[4*i +: 4];
      end

      // chain carries the carry (up) or borrow (down) from digit to digit;
      // if it survives every digit the step wrapped.
      step_val = '0;
      chain    = 1'b1;
      dig      = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         dig = bcd_q[4*i +: 4];
         if (dig > 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
            chain              = 1'b0;
         end else if (!chain) begin
            step_val[4*i +: 4] = dig;
         end else if (!down) begin
            if (dig == 4'd9) begin
               step_val[4*i +: 4] = 4'd0;
            end else begin
               step_val[4*i +: 4] = dig + 4'd1;
               chain              = 1'b0;
            end
         end else begin
            if (dig == 4'd0) begin
               step_val[4*i +: 4] = 4'd9;
            end else begin
               step_val[4*i +: 4] = dig - 4'd1;
               chain              = 1'b0;
            end
         end
      end

      step   = tick & running_q & ~load;
      bcd_d  = bcd_q;
      wrap_d = 1'b0;
      if (load) begin
         bcd_d = ld_clean;
      end else if (step) begin
         bcd_d  = step_val;
         wrap_d = chain;
      end

      running_d = running_q ^ run_toggle;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         bcd_q     <= '0;
         wrap_q    <= 1'b0;
         running_q <= RUN_RESET;
      end else begin
         bcd_q     <= bcd_d;
         wrap_q    <= wrap_d;
         running_q <= running_d;
      end
   end

   assign bcd     = bcd_q;
   assign running = running_q;
   assign wrap    = wrap_q;

endmodule
